iso7816_atr_parser: RTL
=======================

Name: iso7816_atr_parser

Overview:
- Consumes the received-byte stream of the ISO7816-3 master's half-duplex UART after cold/warm reset and decodes the Answer-To-Reset.
- Extracts TA1, TC1, the offered protocols and the historical bytes, and checks TS and TCK.
- Drives the UART read strobe directly. Sits downstream of the master and feeds the protocol/PPS controller.

Parameters:
- MAX_ATR_BYTES, 33, maximum ATR length including TS; exceeding it is an error.
- TA1_DEFAULT, 8'h11, value reported on ta1 when TA1 is absent (Fi/Di default).
- TC1_DEFAULT, 8'h00, value reported on tc1 when TC1 is absent.

Ports:
- clk  input  1  system clock, same domain as the master's UART interface
- nReset  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; clears results and begins parsing (issued when the master activates)
- rxData  input  8  UART dataOut; logical byte value, convention decoded upstream
- rxFull  input  1  UART bufferFull flag
- nCsDataOut  output  1  active-low read strobe to the UART
- busy  output  1  parse in progress
- atrDone  output  1  ATR complete and valid; held until next start
- atrError  output  1  parse aborted; held until next start
- errorCode  output  3  0 none, 1 bad TS, 2 TCK mismatch, 3 length overflow
- ta1  output  8  TA1 or TA1_DEFAULT
- tc1  output  8  TC1 or TC1_DEFAULT
- protocols  output  16  bit n set if any TDi offered T=n; bit 0 is set when no TD1 is present
- firstProtocol  output  4  T from TD1, else 0
- histData  output  8  current historical byte
- histValid  output  1  one-cycle strobe qualifying histData
- histCount  output  4  K from T0

Behaviour:
- Reset values:
  - nCsDataOut=1; busy=atrDone=atrError=histValid=0.
  - errorCode=0, ta1=TA1_DEFAULT, tc1=TC1_DEFAULT, protocols=0, firstProtocol=0, histData=0, histCount=0.
- States: IDLE, TS, T0, IFACE, HIST, TCK, DONE, ERR.
- Start:
  - start in any state reinitialises all result outputs to reset values and enters TS with busy=1.
  - start wins over a simultaneous rxFull; that byte is not consumed.
- Read handshake:
  - In TS/T0/IFACE/HIST/TCK, when rxFull=1 and not in read-wait, drive nCsDataOut=0 for exactly one cycle and capture rxData on that edge.
  - Then enter read-wait until rxFull=0 before another strobe. rxFull is never re-read while still high from the same byte.
- Byte processing takes effect on the edge that captures it; outputs update that same edge, and histValid pulses that cycle.
- Byte counter counts every captured byte including TS. If it would exceed MAX_ATR_BYTES, go to ERR code 3 without consuming further bytes.
- TS: 8'h3B or 8'h3F goes to T0; any other value goes to ERR code 1.
- T0:
  - Load Y mask = high nibble and histCount = low nibble.
  - Set interface index i=1 and XOR accumulator = byte.
- IFACE:
  - Consume the present bytes in order TAi, TBi, TCi, TDi per the Y mask bits 0..3.
  - TA1 stores to ta1; TC1 stores to tc1. Other TA/TB/TC bytes are consumed only.
  - TDi: set protocols[T], record firstProtocol when i=1, mark TCK required if T≠0, load the new Y mask, increment i.
  - Empty mask with histCount>0 goes to HIST.
  - Empty mask with histCount=0 goes to TCK if required, else DONE.
- HIST: stream each byte with histValid; after K bytes go to TCK if required, else DONE.
- Accumulator XORs every byte from T0 onward, TCK included.
- TCK: accumulator == 0 after TCK goes to DONE, else ERR code 2.
- DONE: atrDone=1, busy=0. ERR: atrError=1, busy=0. Both hold until start or reset.
- If no TD1 is present, protocols[0]=1 at DONE.
- nReset low at any time asynchronously forces reset values, including mid-byte and during read-wait.

Test Plan:
- 3B 00 → DONE after 2 strobes; protocols=0x0001, firstProtocol=0, ta1=0x11, tc1=0x00, no TCK expected, errorCode=0.
- 3B 13 96 41 42 43 → ta1=0x96, histCount=3, three histValid pulses with data 41,42,43, atrDone=1.
- 3B 80 01 81 → protocols=0x0002, firstProtocol=1, TCK accepted, atrDone=1. Same sequence with last byte 80 → atrError=1, errorCode=2.
- 3A → atrError after first byte, errorCode=1, no further strobes while rxFull is held high.
- 3B 80 followed by repeated 80 bytes → errorCode=3 at byte 34, exactly 33 strobes issued. Also: rxFull held high 5 cycles yields a single nCsDataOut pulse.
- Pulse nReset mid-HIST, then start with rxFull=1 on the same cycle → outputs at reset values, byte not consumed until the following cycle.

Source files
------------

// File: rtl/iso7816_atr_parser_if.sv
// UART receive-side handshake between the ISO7816 master's UART and the ATR parser.
// master = UART (presents bytes), slave = parser (drives the active-low read strobe).
interface iso7816_atr_parser_if;
  logic [7:0] rxData;
  logic       rxFull;
  logic       nCsDataOut;

  modport master (output rxData, output rxFull, input nCsDataOut);
  modport slave  (input rxData, input rxFull, output nCsDataOut);
endinterface

// File: rtl/iso7816_atr_parser.sv
// ISO7816-3 Answer-To-Reset decoder: reads bytes from the UART, checks TS/TCK,
// extracts TA1/TC1/protocols and streams the historical bytes.
module iso7816_atr_parser #(
  parameter int unsigned MAX_ATR_BYTES = 33,
  parameter logic [7:0]  TA1_DEFAULT   = 8'h11,
  parameter logic [7:0]  TC1_DEFAULT   = 8'h00
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                start,
  iso7816_atr_parser_if.slave uart,
  output logic                busy,
  output logic                atrDone,
  output logic                atrError,
  output logic [2:0]          errorCode,
  output logic [7:0]          ta1,
  output logic [7:0]          tc1,
  output logic [15:0]         protocols,
  output logic [3:0]          firstProtocol,
  output logic [7:0]          histData,
  output logic                histValid,
  output logic [3:0]          histCount
);
  localparam int unsigned CNT_W = $clog2(MAX_ATR_BYTES + 1);

  typedef enum logic [2:0] {IDLE, TS, T0, IFACE, HIST, TCK, DONE, ERR} state_t;

  state_t           state, stateNext;
  logic             readWait, readWaitNext;
  logic [CNT_W-1:0] byteCount, byteCountNext;
  logic [3:0]       yMask, yMaskNext;
  logic [3:0]       histRemain, histRemainNext;
  logic [5:0]       ifaceIdx, ifaceIdxNext;
  logic [7:0]       xorAcc, xorAccNext;
  logic             tckReq, tckReqNext;
  logic             td1Seen, td1SeenNext;
  logic [2:0]       errorCodeNext;
  logic [7:0]       ta1Next, tc1Next, histDataNext;
  logic [15:0]      protocolsNext;
  logic [3:0]       firstProtocolNext, histCountNext;
  logic             histValidNext;
  logic             strobe;
  logic [7:0]       rxByte;
  logic [3:0]       ifaceMask;

  function automatic state_t afterIface(input logic [3:0] k, input logic tck);
    if (k != 4'd0)
      return HIST;
    else if (tck)
      return TCK;
    else
      return DONE;
  endfunction

  assign rxByte          = uart.rxData;
  assign uart.nCsDataOut = ~strobe;
  assign busy            = (state == TS) || (state == T0) || (state == IFACE) ||
                           (state == HIST) || (state == TCK);
  assign atrDone         = (state == DONE);
  assign atrError        = (state == ERR);

  always_comb begin
    stateNext         = state;
    readWaitNext      = readWait;
    byteCountNext     = byteCount;
    yMaskNext         = yMask;
    histRemainNext    = histRemain;
    ifaceIdxNext      = ifaceIdx;
    xorAccNext        = xorAcc;
    tckReqNext        = tckReq;
    td1SeenNext       = td1Seen;
    errorCodeNext     = errorCode;
    ta1Next           = ta1;
    tc1Next           = tc1;
    protocolsNext     = protocols;
    firstProtocolNext = firstProtocol;
    histDataNext      = histData;
    histCountNext     = histCount;
    histValidNext     = 1'b0;
    strobe            = 1'b0;
    ifaceMask         = yMask;

    if (start) begin
      // Start outranks a pending byte: it is left in the UART for the next cycle.
      stateNext         = TS;
      readWaitNext      = 1'b0;
      byteCountNext     = '0;
      yMaskNext         = '0;
      histRemainNext    = '0;
      ifaceIdxNext      = '0;
      xorAccNext        = '0;
      tckReqNext        = 1'b0;
      td1SeenNext       = 1'b0;
      errorCodeNext     = 3'd0;
      ta1Next           = TA1_DEFAULT;
      tc1Next           = TC1_DEFAULT;
      protocolsNext     = '0;
      firstProtocolNext = '0;
      histDataNext      = '0;
      histCountNext     = '0;
    end else begin
      if (!uart.rxFull)
        readWaitNext = 1'b0;
      if (busy && uart.rxFull && !readWait) begin
        if (byteCount >= CNT_W'(MAX_ATR_BYTES)) begin
          stateNext     = ERR;
          errorCodeNext = 3'd3;
        end else begin
          strobe        = 1'b1;
          readWaitNext  = 1'b1;
          byteCountNext = byteCount + 1'b1;
          if (state != TS)
            xorAccNext = xorAcc ^ rxByte;
          unique case (state)
            TS: begin
              if (rxByte == 8'h3B || rxByte == 8'h3F) begin
                stateNext = T0;
              end else begin
                stateNext     = ERR;
                errorCodeNext = 3'd1;
              end
            end
            T0: begin
              yMaskNext      = rxByte[7:4];
              histCountNext  = rxByte[3:0];
              histRemainNext = rxByte[3:0];
              ifaceIdxNext   = 6'd1;
              stateNext      = (rxByte[7:4] != 4'd0) ? IFACE : afterIface(rxByte[3:0], tckReq);
            end
            IFACE: begin
              // Lowest set Y bit names the byte in hand; TD reloads the mask.
              if (yMask[0]) begin
                if (ifaceIdx == 6'd1) ta1Next = rxByte;
                ifaceMask[0] = 1'b0;
              end else if (yMask[1]) begin
                ifaceMask[1] = 1'b0;
              end else if (yMask[2]) begin
                if (ifaceIdx == 6'd1) tc1Next = rxByte;
                ifaceMask[2] = 1'b0;
              end else begin
                protocolsNext[rxByte[3:0]] = 1'b1;
                if (ifaceIdx == 6'd1) begin
                  firstProtocolNext = rxByte[3:0];
                  td1SeenNext       = 1'b1;
                end
                if (rxByte[3:0] != 4'd0) tckReqNext = 1'b1;
                ifaceMask    = rxByte[7:4];
                ifaceIdxNext = ifaceIdx + 6'd1;
              end
              yMaskNext = ifaceMask;
              stateNext = (ifaceMask != 4'd0) ? IFACE : afterIface(histCount, tckReqNext);
            end
            HIST: begin
              histDataNext   = rxByte;
              histValidNext  = 1'b1;
              histRemainNext = histRemain - 4'd1;
              if (histRemain == 4'd1)
                stateNext = tckReq ? TCK : DONE;
            end
            TCK: begin
              if ((xorAcc ^ rxByte) == 8'h00) begin
                stateNext = DONE;
              end else begin
                stateNext     = ERR;
                errorCodeNext = 3'd2;
              end
            end
            default: ;
          endcase
        end
      end
      if (stateNext == DONE && state != DONE && !td1SeenNext)
        protocolsNext[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state         <= IDLE;
      readWait      <= 1'b0;
      byteCount     <= '0;
      yMask         <= '0;
      histRemain    <= '0;
      ifaceIdx      <= '0;
      xorAcc        <= '0;
      tckReq        <= 1'b0;
      td1Seen       <= 1'b0;
      errorCode     <= 3'd0;
      ta1           <= TA1_DEFAULT;
      tc1           <= TC1_DEFAULT;
      protocols     <= '0;
      firstProtocol <= '0;
      histData      <= '0;
      histValid     <= 1'b0;
      histCount     <= '0;
    end else begin
      state         <= stateNext;
      readWait      <= readWaitNext;
      byteCount     <= byteCountNext;
      yMask         <= yMaskNext;
      histRemain    <= histRemainNext;
      ifaceIdx      <= ifaceIdxNext;
      xorAcc        <= xorAccNext;
      tckReq        <= tckReqNext;
      td1Seen       <= td1SeenNext;
      errorCode     <= errorCodeNext;
      ta1           <= ta1Next;
      tc1           <= tc1Next;
      protocols     <= protocolsNext;
      firstProtocol <= firstProtocolNext;
      histData      <= histDataNext;
      histValid     <= histValidNext;
      histCount     <= histCountNext;
    end
  end
endmodule
